// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision types and constants for the FPU datapath.
package fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} div_state_t;

  localparam int          FP_BIAS    = 127;
  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

  localparam int FLG_INVALID = 3;
  localparam int FLG_DZ      = 2;
  localparam int FLG_OF      = 1;
  localparam int FLG_UF      = 0;

endpackage

// File: rtl/fp_div_step.sv
// One restoring radix-2 division step; the returned remainder is pre-shifted for the next step.
module fp_div_step (
  input  logic [25:0] rem,
  input  logic [23:0] divisor,
  output logic [25:0] next_rem,
  output logic        qbit
);

  logic [24:0] diff;
  logic [24:0] kept;

  // Partial remainder stays below 2*divisor, so bit 25 is only needed for the compare.
  always_comb begin
    diff     = rem[24:0] - {1'b0, divisor};
    qbit     = (rem >= {2'b00, divisor});
    kept     = qbit ? diff : rem[24:0];
    next_rem = {kept, 1'b0};
  end

endmodule

// File: rtl/fp_divider.sv
// Sequential IEEE-754 single divider, restoring mantissa division, FTZ; valid/ready both sides.
// Define FP_DIV_RNE_EN for round-to-nearest-even, otherwise results truncate toward zero.
module fp_divider
  import fp_pkg::*;
#(
  parameter int QBITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic [3:0]  flags,
  output logic        busy
);

  localparam int STEPS = 26 / QBITS_PER_CYCLE;
  localparam logic signed [9:0] BIAS_S = 10'(FP_BIAS);

  div_state_t state, state_n;
  fp32_t fa, fb;
  logic sign_in, sign;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic spec_hit;
  logic [31:0] spec_out, norm_out;
  logic [3:0] spec_flags, norm_flags;
  logic signed [9:0] diff, exp_r;
  logic [23:0] mb;
  logic [25:0] rem, q;
  logic [4:0] cnt;
  logic [22:0] mant_r;
  logic [25:0] chain_rem [QBITS_PER_CYCLE+1];
  logic [QBITS_PER_CYCLE-1:0] chain_q;

  assign fa        = a;
  assign fb        = b;
  assign sign_in   = fa.sign ^ fb.sign;
  assign a_nan     = (fa.exp == FP_EXP_MAX) && (fa.frac != '0);
  assign b_nan     = (fb.exp == FP_EXP_MAX) && (fb.frac != '0);
  assign a_inf     = (fa.exp == FP_EXP_MAX) && (fa.frac == '0);
  assign b_inf     = (fb.exp == FP_EXP_MAX) && (fb.frac == '0);
  assign a_zero    = (fa.exp == '0);
  assign b_zero    = (fb.exp == '0);
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    spec_hit   = 1'b1;
    spec_out   = FP_QNAN;
    spec_flags = '0;
    if (a_nan || b_nan) begin
      spec_out = FP_QNAN;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_flags[FLG_INVALID] = 1'b1;
    end else if (a_inf) begin
      spec_out = {sign_in, FP_EXP_MAX, 23'd0};
    end else if (b_inf) begin
      spec_out = {sign_in, 31'd0};
    end else if (b_zero) begin
      spec_out             = {sign_in, FP_EXP_MAX, 23'd0};
      spec_flags[FLG_DZ]   = 1'b1;
    end else if (a_zero) begin
      spec_out = {sign_in, 31'd0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  assign chain_rem[0] = rem;
  for (genvar g = 0; g < QBITS_PER_CYCLE; g++) begin : g_step
    fp_div_step u_step (
      .rem      (chain_rem[g]),
      .divisor  (mb),
      .next_rem (chain_rem[g+1]),
      .qbit     (chain_q[QBITS_PER_CYCLE-1-g])
    );
  end

  always_comb begin
    exp_r  = q[25] ? diff + BIAS_S : diff + BIAS_S - 10'sd1;
    mant_r = q[25] ? q[24:2] : q[23:1];
`ifdef FP_DIV_RNE_EN
    begin : g_rne
      logic guard, sticky;
      logic [23:0] inc;
      guard  = q[25] ? q[1] : q[0];
      sticky = (q[25] & q[0]) | (rem != '0);
      inc    = {1'b0, mant_r} + 24'(guard & (sticky | mant_r[0]));
      mant_r = inc[22:0];
      if (inc[23]) exp_r = exp_r + 10'sd1;
    end
`endif
    norm_flags = '0;
    if (exp_r >= 10'sd255) begin
      norm_out           = {sign, FP_EXP_MAX, 23'd0};
      norm_flags[FLG_OF] = 1'b1;
    end else if (exp_r <= 10'sd0) begin
      norm_out           = {sign, 31'd0};
      norm_flags[FLG_UF] = 1'b1;
    end else begin
      norm_out = {sign, exp_r[7:0], mant_r};
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_n = spec_hit ? DONE : DIVIDE;
      DIVIDE:  if (cnt == 5'(STEPS - 1)) state_n = NORM;
      NORM:    state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign  <= 1'b0;
      diff  <= '0;
      mb    <= '0;
      rem   <= '0;
      q     <= '0;
      cnt   <= '0;
      out   <= '0;
      flags <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          sign  <= sign_in;
          diff  <= $signed({2'b00, fa.exp}) - $signed({2'b00, fb.exp});
          mb    <= {1'b1, fb.frac};
          rem   <= {3'b001, fa.frac};
          q     <= '0;
          cnt   <= '0;
          out   <= spec_out;
          flags <= spec_flags;
        end
        DIVIDE: begin
          rem <= chain_rem[QBITS_PER_CYCLE];
          q   <= {q[25-QBITS_PER_CYCLE:0], chain_q};
          cnt <= cnt + 5'd1;
        end
        NORM: begin
          out   <= norm_out;
          flags <= norm_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divider.sv
// Scoreboard bench for fp_divider: directed vectors, latency, backpressure and mid-operation reset.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out;
  logic [3:0]  flags;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] o;
    logic [3:0]  f;
    int          lat;
    time         ta;
  } exp_t;

  exp_t sb[$];
  logic seen = 1'b0;

  always #5 clk = ~clk;

  fp_divider dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: first negedge of each out_valid episode pops one expectation.
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else if (out_valid && !seen) begin : mon
      exp_t e;
      seen = 1'b1;
      if (sb.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("out", out, e.o);
        check("flags", {28'd0, flags}, {28'd0, e.f});
        check("latency", 32'(($time - e.ta + 5) / 10), 32'(e.lat));
      end
    end
    if (out_valid && out_ready) seen = 1'b0;
  end

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] eo, input logic [3:0] ef, input int lat);
    exp_t e;
    int n;
    n = 0;
    @(posedge clk); #1;
    a = ia; b = ib; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      e.o = eo; e.f = ef; e.lat = lat;
      @(posedge clk);
      e.ta = $time;
      sb.push_back(e);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || busy) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out", out, 32'd0);
    check("rst_flags", {28'd0, flags}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    issue(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);
    wait_idle();
`ifdef FP_DIV_RNE_EN
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28);
`else
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 28);
`endif
    issue(32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 28);
    issue(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 1);
    issue(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 1);
    issue(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1);
    issue(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000, 1);
    issue(32'h3F800000, 32'h7F800000, 32'h00000000, 4'b0000, 1);
    issue(32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 1);
    issue(32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 28);
    issue(32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 28);
    wait_idle();

    // Backpressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);
    begin : bp
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("bp_out_hold", out, 32'h40400000);
        check("bp_flags_hold", {28'd0, flags}, 32'd0);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        if (i == 1) begin
          a = 32'h3F800000; b = 32'h00000000; in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_busy", {31'd0, busy}, 32'd0);
      check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (40) @(negedge clk);
    end

    // Reset in the middle of a normal divide: the pending result must vanish.
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);
    wait_idle();
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
